// File: rtl/mips_muldiv_unit.sv
// mips_muldiv_unit
//
// Iterative multiply/divide unit that owns the architectural HI/LO pair.
// MULT/MULTU use radix-2 shift-add and DIV/DIVU use restoring division, both
// on operand magnitudes with the sign applied in a final FIX cycle. MTHI/MTLO
// write HI/LO directly on the accepting edge.
//
// Optional feature: define MULT_ACC_EN to enable MADD (op 6) and MSUB (op 7),
// which run as a signed MULT and then accumulate into {hi,lo}. Without it,
// ops 6/7 are accepted as no-ops that complete on the next cycle.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request, accepted only while busy=0
//   op[2:0]      0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MSUB
//   src_a        rs operand (multiplicand / dividend / MTHI-MTLO data)
//   src_b        rt operand (multiplier / divisor)
//   abort        synchronous flush of an in-flight operation
//   busy         operation in flight
//   done         one-cycle completion pulse
//   div_by_zero  valid with done; divisor was zero
//   hi, lo       HI/LO registers
module mips_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  // Iteration counter width; derived from WIDTH, not meant to be overridden.
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
`ifdef MULT_ACC_EN
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MSUB  = 3'd7;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  // MUL: {partial product, remaining multiplier}; DIV: {remainder, quotient}
  logic [2*WIDTH-1:0] acc_q, acc_d;
  // MUL: multiplicand magnitude; DIV: divisor magnitude
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic               neg_q, neg_d;         // product / quotient sign
  logic               rem_neg_q, rem_neg_d; // remainder follows the dividend
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  logic               acc_en_op, is_mul, is_div, is_signed;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift, div_diff;
  logic               div_ge;
  logic               fix_is_div, div_zero;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  // Operand decode and magnitude conversion for the request on the inputs.
  always_comb begin
    acc_en_op = 1'b0;
`ifdef MULT_ACC_EN
    acc_en_op = (op == OP_MADD) || (op == OP_MSUB);
`endif
    is_mul    = (op == OP_MULT) || (op == OP_MULTU) || acc_en_op;
    is_div    = (op == OP_DIV) || (op == OP_DIVU);
    is_signed = (op == OP_MULT) || (op == OP_DIV) || acc_en_op;
    a_neg     = is_signed & src_a[WIDTH-1];
    b_neg     = is_signed & src_b[WIDTH-1];
    a_mag     = a_neg ? -src_a : src_a;
    b_mag     = b_neg ? -src_b : src_b;
  end

  // Datapath for one iteration and for the FIX-cycle sign correction.
  always_comb begin
    mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    div_shift  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge     = div_shift >= {1'b0, opb_q};
    div_diff   = div_shift - {1'b0, opb_q};
    fix_is_div = (op_q == OP_DIV) || (op_q == OP_DIVU);
    div_zero   = (opb_q == '0);
    prod_fix   = neg_q ? -acc_q : acc_q;
    // With a zero divisor the quotient is forced to all ones; the remainder
    // already holds |a|, and the dividend-sign correction turns it back into
    // the original src_a.
    quot_fix   = div_zero ? '1 : (neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
    rem_fix    = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    op_d      = op_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dbz_d     = 1'b0;

    if (abort) begin
      // Flush wins over everything, including a start on the same edge.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_d  = op;
            cnt_d = '0;
            if (is_mul || is_div) begin
              state_d   = is_mul ? S_MUL : S_DIV;
              neg_d     = a_neg ^ b_neg;
              rem_neg_d = a_neg;
              acc_d     = is_mul ? {{WIDTH{1'b0}}, b_mag} : {{WIDTH{1'b0}}, a_mag};
              opb_d     = is_mul ? a_mag : b_mag;
            end else if (op == OP_MTHI) begin
              hi_d   = src_a;
              done_d = 1'b1;
            end else if (op == OP_MTLO) begin
              lo_d   = src_a;
              done_d = 1'b1;
            end else begin
              // Accumulate ops with the feature compiled out: plain no-op.
              done_d = 1'b1;
            end
          end
        end
        S_MUL: begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_ITER) state_d = S_FIX;
        end
        S_DIV: begin
          acc_d = div_ge ? {WIDTH'(div_diff), acc_q[WIDTH-2:0], 1'b1}
                         : {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_ITER) state_d = S_FIX;
        end
        S_FIX: begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          cnt_d   = '0;
          if (fix_is_div) begin
            lo_d  = quot_fix;
            hi_d  = rem_fix;
            dbz_d = div_zero;
          end else begin
`ifdef MULT_ACC_EN
            if (op_q == OP_MADD)      {hi_d, lo_d} = {hi_q, lo_q} + prod_fix;
            else if (op_q == OP_MSUB) {hi_d, lo_d} = {hi_q, lo_q} - prod_fix;
            else                      {hi_d, lo_d} = prod_fix;
`else
            {hi_d, lo_d} = prod_fix;
`endif
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      op_q      <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      op_q      <= op_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Testbench for mips_muldiv_unit (WIDTH=32). Directed steps in one initial
// block; expected results are queued when a request is driven and compared
// when done is observed. Inputs change and outputs are sampled on the falling
// clock edge.
`timescale 1ns/1ps
module tb_mips_muldiv_unit;
  localparam int W = 32;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MSUB  = 3'd7;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;

  typedef struct {
    string        tag;
    logic [2:0]   op;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           lat;
    int           busy_cycles;
  } exp_t;
  exp_t sb[$];

  mips_muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .abort(abort),
    .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Reference results from plain SV arithmetic: {dbz, hi, lo}.
  function automatic logic [64:0] model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] p;
    logic [W-1:0] q, r;
    logic z;
    z = 1'b0;
    q = '0;
    r = '0;
    case (o)
      OP_MULT:  p = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
      OP_MULTU: p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      default: begin
        if (b == '0) begin
          q = '1; r = a; z = 1'b1;
        end else if (o == OP_DIV) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; r = '0;
          end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
          end
        end else begin
          q = a / b;
          r = a % b;
        end
        p = {r, q};
      end
    endcase
    return {z, p};
  endfunction

  // Drive a request for one cycle; afterwards the inputs are scrambled to
  // show that only the latched copy matters.
  task automatic launch(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    op = o; src_a = a; src_b = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op = 3'($urandom_range(0, 7));
    src_a = $urandom;
    src_b = $urandom;
  endtask

  task automatic issue(input string tag, input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edbz,
                       input int lat, input int bcyc);
    exp_t e;
    e.tag = tag; e.op = o; e.hi = ehi; e.lo = elo; e.dbz = edbz;
    e.lat = lat; e.busy_cycles = bcyc;
    sb.push_back(e);
    exp_hi = ehi;
    exp_lo = elo;
    launch(o, a, b);
  endtask

  // Wait (bounded) for done, optionally poking start at two sample indices,
  // then pop the scoreboard and compare.
  task automatic finish_txn(input int poke1, input int poke2);
    exp_t e;
    int n;
    int bc;
    n = 0;
    bc = 0;
    while (done !== 1'b1 && n < 100) begin
      if (busy === 1'b1) bc++;
      @(negedge clk);
      n++;
      start = (n == poke1) || (n == poke2);
      if (start) begin
        op = OP_MTHI;
        src_a = 32'hDEAD_BEEF;
      end
    end
    start = 1'b0;
    e = sb.pop_front();
    chk({e.tag, "_lat"}, 64'(n), 64'(e.lat));
    chk({e.tag, "_busy_cycles"}, 64'(bc), 64'(e.busy_cycles));
    chk({e.tag, "_busy_at_done"}, 64'(busy), 64'(0));
    chk({e.tag, "_hi"}, 64'(hi), 64'(e.hi));
    chk({e.tag, "_lo"}, 64'(lo), 64'(e.lo));
    chk({e.tag, "_dbz"}, 64'(div_by_zero), 64'(e.dbz));
    $display("txn %-14s op=%0d lat=%0d hi=%h lo=%h dbz=%b", e.tag, e.op, n, hi, lo, div_by_zero);
  endtask

  task automatic run(input string tag, input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edbz,
                     input int lat, input int bcyc);
    issue(tag, o, a, b, ehi, elo, edbz, lat, bcyc);
    finish_txn(-1, -1);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 64'(done), 64'(0));
    chk({tag, "_dbz_after"}, 64'(div_by_zero), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [64:0] m;
    logic [2:0]  ro;
    logic [W-1:0] ra, rb;
    int cnt;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_hi", 64'(hi), 64'(0));
    chk("rst_lo", 64'(lo), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_dbz", 64'(div_by_zero), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    run("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33, 33);

    // MULT then DIV started in the done cycle
    issue("mult_neg", OP_MULT, 32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b0, 33, 33);
    finish_txn(-1, -1);
    issue("div_b2b", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33, 33);
    chk("b2b_busy", 64'(busy), 64'(1));
    chk("b2b_done_clear", 64'(done), 64'(0));
    finish_txn(-1, -1);
    @(negedge clk);
    chk("div_b2b_done_pulse", 64'(done), 64'(0));

    run("div_mixed", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 33, 33);
    run("divu_zero", OP_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1'b1, 33, 33);
    run("div_zero_neg", OP_DIV, 32'hFFFF_FF00, 32'd0, 32'hFFFF_FF00, 32'hFFFF_FFFF, 1'b1, 33, 33);
    run("div_minneg", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 33, 33);
    run("mthi", OP_MTHI, 32'h1234_5678, 32'd0, 32'h1234_5678, exp_lo, 1'b0, 0, 0);
    run("mtlo", OP_MTLO, 32'hCAFE_BABE, 32'd0, exp_hi, 32'hCAFE_BABE, 1'b0, 0, 0);

    // Start pulses while a DIVU runs are ignored
    issue("divu_poked", OP_DIVU, 32'd1000, 32'd7, 32'd6, 32'd142, 1'b0, 33, 33);
    finish_txn(5, 20);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) cnt++;
    end
    chk("poke_single_done", 64'(cnt), 64'(0));
    chk("poke_hi_kept", 64'(hi), 64'(6));

    // Randomised operands against the arithmetic model
    for (int i = 0; i < 5; i++) begin
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i == 2) ? 32'($urandom_range(1, 9)) : $urandom;
      m = model(ro, ra, rb);
      run("rand", ro, ra, rb, m[63:32], m[31:0], m[64], 33, 33);
    end

    // Abort at cycle 10 of a DIVU
    launch(OP_DIVU, 32'd55, 32'd5);
    repeat (10) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'(0));
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) cnt++;
    end
    chk("abort_no_done", 64'(cnt), 64'(0));
    chk("abort_hi", 64'(hi), 64'(exp_hi));
    chk("abort_lo", 64'(lo), 64'(exp_lo));
    $display("txn abort          op=%0d hi=%h lo=%h", OP_DIVU, hi, lo);

    // Abort beats start on the same edge
    abort = 1'b1; start = 1'b1; op = OP_MTHI; src_a = 32'hA5A5_A5A5;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    chk("abort_start_done", 64'(done), 64'(0));
    chk("abort_start_busy", 64'(busy), 64'(0));
    chk("abort_start_hi", 64'(hi), 64'(exp_hi));
    $display("txn abort_start    op=%0d hi=%h lo=%h", OP_MTHI, hi, lo);

    // Asynchronous reset mid-MULT, between clock edges
    launch(OP_MULT, 32'd123, 32'd456);
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_hi", 64'(hi), 64'(0));
    chk("arst_lo", 64'(lo), 64'(0));
    chk("arst_done", 64'(done), 64'(0));
    chk("arst_dbz", 64'(div_by_zero), 64'(0));
    $display("txn async_reset    hi=%h lo=%h busy=%b", hi, lo, busy);
    exp_hi = '0;
    exp_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

`ifdef MULT_ACC_EN
    run("mthi_acc", OP_MTHI, 32'd0, 32'd0, 32'd0, exp_lo, 1'b0, 0, 0);
    run("mtlo_acc", OP_MTLO, 32'hFFFF_FFFF, 32'd0, exp_hi, 32'hFFFF_FFFF, 1'b0, 0, 0);
    run("madd", OP_MADD, 32'd2, 32'd3, 32'd1, 32'd5, 1'b0, 33, 33);
    run("msub", OP_MSUB, 32'd1, 32'd6, 32'd0, 32'hFFFF_FFFF, 1'b0, 33, 33);
`else
    run("mthi_nop", OP_MTHI, 32'h0F0F_0F0F, 32'd0, 32'h0F0F_0F0F, exp_lo, 1'b0, 0, 0);
    run("madd_nop", OP_MADD, 32'd2, 32'd3, exp_hi, exp_lo, 1'b0, 0, 0);
    run("msub_nop", OP_MSUB, 32'd1, 32'd6, exp_hi, exp_lo, 1'b0, 0, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_muldiv_unit.md
Name: mips_muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit for the MIPS integer datapath.
- Holds the architectural HI/LO register pair.
- Executes MULT/MULTU/DIV/DIVU over multiple cycles with a start/busy/done handshake, plus single-cycle MTHI/MTLO writes.
- Sits beside the single-cycle ALU. The control path stalls PC while busy is high and reads hi/lo for MFHI/MFLO.

Parameters:
WIDTH, 32, operand width in bits; hi and lo are each WIDTH bits; must be even and >= 4.
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; not to be overridden).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled on rising edge, accepted only when the unit is idle (busy=0)
op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MSUB
src_a  input  WIDTH  rs operand (multiplicand/dividend; MTHI/MTLO data)
src_b  input  WIDTH  rt operand (multiplier/divisor)
abort  input  1  synchronous flush; cancels an in-flight operation
busy  output  1  operation in flight
done  output  1  one-cycle completion pulse
div_by_zero  output  1  valid with done; divisor was zero
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE; hi=0, lo=0, busy=0, done=0, div_by_zero=0; counter cleared.
- States: IDLE, MUL, DIV, FIX.
  - IDLE: accepts start.
  - MUL/DIV: run WIDTH iterations, one per cycle.
  - FIX: one cycle; sign correction and HI/LO commit.
- Acceptance edge (start=1 in IDLE):
  - operands are latched into internal registers;
  - later src_a/src_b/op changes have no effect.
- MULT/MULTU:
  - Radix-2 shift-add on magnitudes (signed ops take absolute values and record the result sign).
  - After WIDTH MUL cycles, FIX negates if needed and writes the 2*WIDTH product: hi = upper half, lo = lower half.
- DIV/DIVU:
  - Restoring division on magnitudes.
  - lo = quotient; hi = remainder.
  - Signed: quotient sign = sign(a) XOR sign(b); remainder takes the sign of the dividend (truncation toward zero).
  - Most-negative / -1: lo = most-negative value, hi = 0. No flag.
  - Divisor zero: full latency still taken; lo = all ones, hi = src_a as latched; div_by_zero=1 with done.
- Latency for mul/div:
  - busy=1 from acceptance edge for WIDTH+1 cycles (WIDTH iteration cycles + FIX).
  - On the (WIDTH+1)th edge after acceptance: hi/lo update, busy falls to 0, done=1 for exactly one cycle.
- MTHI/MTLO:
  - hi (resp. lo) is written with src_a on the acceptance edge.
  - busy stays 0; done=1 in the following cycle; div_by_zero=0.
- div_by_zero is 0 whenever done is 0, and 0 for all non-divide completions.
- Start while busy=1: ignored, no queueing. Start in the done cycle: accepted (back-to-back; done and busy may be high together for that new op's first cycle only if busy rises on the same edge, i.e. done from prior op, busy from new).
- abort=1 on an edge:
  - state returns to IDLE, busy=0, no done, hi/lo unchanged.
  - abort has priority over start on the same edge; that start is dropped.
- HI/LO are never partially updated; intermediate values live in internal registers only.
- Op codes 6/7 without MULT_ACC_EN: accepted as a no-op; done pulses next cycle; hi/lo unchanged.

Optional Feature:
- Macro MULT_ACC_EN.
- Defined: op 6 MADD and op 7 MSUB run as signed MULT, then FIX adds (MADD) or subtracts (MSUB) the product to/from {hi,lo}, modulo 2^(2*WIDTH). Latency is identical to MULT.
- Undefined: ops 6/7 are the no-op described above, and no accumulate adder is synthesised.

Test Plan:
- Reset then MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy 33 cycles, done pulse; hi=0xFFFFFFFE lo=0x00000001.
- MULT a=-7 (0xFFFFFFF9) b=6 -> hi=0xFFFFFFFF lo=0xFFFFFFD6; then back-to-back DIV a=-7 b=2 started in the done cycle -> lo=0xFFFFFFFD hi=0xFFFFFFFF.
- DIVU a=100 b=0 -> done after 33 cycles with div_by_zero=1, lo=0xFFFFFFFF hi=100; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000 hi=0, div_by_zero=0.
- MTHI 0x12345678, MTLO 0xCAFEBABE -> busy never rises, done one cycle later each, hi/lo read back exactly; start pulses during a running DIV are ignored (result unchanged, single done).
- DIVU started, abort at cycle 10 -> busy drops next edge, no done, hi/lo retain prior values; rst_n pulled low mid-MULT (asynchronous, between edges) -> all outputs zero immediately.
- With MULT_ACC_EN: hi=0 lo=0xFFFFFFFF, MADD 2*3 -> hi=1 lo=5; MSUB 1*6 -> hi=0 lo=0xFFFFFFFF.
